// File: rtl/collision_pkg.sv
// collision_pkg: shared latch state type and default active-area geometry
package collision_pkg;
  typedef enum logic {ARMED, FIRED} latch_state_t;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
endpackage

// File: rtl/collision_latch.sv
// collision_latch: once-per-frame event latch issuing a single registered pulse
module collision_latch
  import collision_pkg::*;
(
  input  logic clk,
  input  logic resetN,
  input  logic sof,
  input  logic event_in,
  output logic pulse_out
);
  latch_state_t state_q, state_d, state_now;
  logic pulse_q, pulse_d;
  // A frame start re-arms before the event is judged, so a coincident event counts in the new frame
  always_comb begin
    state_now = sof ? ARMED : state_q;
    pulse_d = (state_now == ARMED) && event_in;
    state_d = pulse_d ? FIRED : state_now;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= ARMED;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
    end
  assign pulse_out = pulse_q;
endmodule

// File: rtl/collision_detector.sv
// collision_detector: masks draw overlaps to the active area, pulses each collision class once per frame, counts ghost hits
module collision_detector
  import collision_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [31:0]      pxl_x,
  input  logic [31:0]      pxl_y,
  input  logic             draw_ghost,
  input  logic             draw_player,
  input  logic             draw_missile,
  input  logic             draw_border,
  output logic             collision_ghost,
  output logic             collision_player,
  output logic             hit_ghost,
  output logic             frame_start,
  output logic [CNT_W-1:0] hit_count
);
  logic active, at_origin, sof;
  logic ov_gb, ov_gm, ov_pg, ov_pb;
  logic prev_origin_q, prev_origin_d;
  logic frame_start_q, frame_start_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  always_comb begin
    active = (pxl_x < 32'(H_ACTIVE)) && (pxl_y < 32'(V_ACTIVE));
    at_origin = (pxl_x == '0) && (pxl_y == '0);
    sof = at_origin && !prev_origin_q;
    ov_gb = active && draw_ghost && draw_border;
    ov_gm = active && draw_ghost && draw_missile;
    ov_pg = active && draw_player && draw_ghost;
    ov_pb = active && draw_player && draw_border;
    prev_origin_d = at_origin;
    frame_start_d = sof;
    hit_count_d = (hit_ghost && hit_count_q != '1) ? hit_count_q + CNT_W'(1) : hit_count_q;
  end
  // prev_origin resets high so coordinates parked at (0,0) through reset do not fake a frame start
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      prev_origin_q <= 1'b1;
      frame_start_q <= 1'b0;
      hit_count_q <= '0;
    end else begin
      prev_origin_q <= prev_origin_d;
      frame_start_q <= frame_start_d;
      hit_count_q <= hit_count_d;
    end
  collision_latch u_ghost (
    .clk(clk), .resetN(resetN), .sof(sof), .event_in(ov_gb | ov_gm), .pulse_out(collision_ghost)
  );
  collision_latch u_player (
    .clk(clk), .resetN(resetN), .sof(sof), .event_in(ov_pg | ov_pb), .pulse_out(collision_player)
  );
  collision_latch u_hit (
    .clk(clk), .resetN(resetN), .sof(sof), .event_in(ov_gm), .pulse_out(hit_ghost)
  );
  assign frame_start = frame_start_q;
  assign hit_count = hit_count_q;
endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: directed and randomized checks against a frame-level reference model
module tb_collision_detector;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic [31:0] pxl_x = '0, pxl_y = '0;
  logic draw_ghost = 1'b0, draw_player = 1'b0, draw_missile = 1'b0, draw_border = 1'b0;
  logic collision_ghost, collision_player, hit_ghost, frame_start;
  logic [7:0] hit_count;
  int checks = 0, failures = 0;
  bit m_fired [3];
  bit m_pulse [3];
  bit m_fs, m_prev_org;
  int m_cnt;
  collision_detector dut (
    .clk(clk), .resetN(resetN), .pxl_x(pxl_x), .pxl_y(pxl_y),
    .draw_ghost(draw_ghost), .draw_player(draw_player), .draw_missile(draw_missile), .draw_border(draw_border),
    .collision_ghost(collision_ghost), .collision_player(collision_player), .hit_ghost(hit_ghost),
    .frame_start(frame_start), .hit_count(hit_count)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_fired[k] = 0;
      m_pulse[k] = 0;
    end
    m_fs = 0;
    m_prev_org = 1;
    m_cnt = 0;
  endtask
  // Drive one pixel for one clock; the model predicts what the outputs show after this edge
  task automatic step(input int x, input int y, input bit g, input bit p, input bit m, input bit b);
    bit org, act, sof;
    bit term [3];
    pxl_x = x; pxl_y = y;
    draw_ghost = g; draw_player = p; draw_missile = m; draw_border = b;
    org = (x == 0) && (y == 0);
    sof = org && !m_prev_org;
    act = (x < 640) && (y < 480);
    term[0] = act && g && (b || m);
    term[1] = act && p && (g || b);
    term[2] = act && g && m;
    if (m_pulse[2] && m_cnt < 255) m_cnt++;
    for (int k = 0; k < 3; k++) begin
      if (sof) m_fired[k] = 0;
      m_pulse[k] = term[k] && !m_fired[k];
      if (m_pulse[k]) m_fired[k] = 1;
    end
    m_fs = sof;
    m_prev_org = org;
    @(posedge clk);
    #1;
  endtask
  task automatic new_frame();
    step(639, 479, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_reset();
    resetN = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({collision_ghost, collision_player, hit_ghost, frame_start, hit_count} !== 12'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000", {collision_ghost, collision_player, hit_ghost, frame_start, hit_count});
    end
    resetN = 1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      checks++;
      if (frame_start !== 1'b0) begin
        failures++;
        $display("FAIL reset_origin_no_sof cycle=%0d got=%b exp=0", i, frame_start);
      end
    end
    step(639, 479, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL first_frame_start got=%b exp=1", frame_start);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (frame_start !== 1'b0) begin
      failures++;
      $display("FAIL frame_start_width got=%b exp=0", frame_start);
    end
  endtask
  task automatic test_ghost_hold();
    int pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(100 + i, 50, 1, 0, 0, 1);
      pulses += int'(collision_ghost);
      checks++;
      if (collision_ghost !== (i == 0)) begin
        failures++;
        $display("FAIL ghost_hold cycle=%0d got=%b exp=%b", i, collision_ghost, i == 0);
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL ghost_hold_count got=%0d exp=1", pulses);
    end
    step(300, 60, 1, 0, 0, 1);
    checks++;
    if (collision_ghost !== 1'b0) begin
      failures++;
      $display("FAIL ghost_no_repeat got=%b exp=0", collision_ghost);
    end
    new_frame();
    step(100, 50, 1, 0, 0, 1);
    checks++;
    if (collision_ghost !== 1'b1) begin
      failures++;
      $display("FAIL ghost_rearm got=%b exp=1", collision_ghost);
    end
  endtask
  task automatic test_hit();
    new_frame();
    step(200, 200, 1, 0, 1, 0);
    checks++;
    if ({collision_ghost, hit_ghost, collision_player} !== 3'b110) begin
      failures++;
      $display("FAIL hit_pulses got=%b exp=110", {collision_ghost, hit_ghost, collision_player});
    end
    step(201, 200, 0, 0, 0, 0);
    checks++;
    if (hit_count !== 8'd1) begin
      failures++;
      $display("FAIL hit_count_inc got=%0d exp=1", hit_count);
    end
  endtask
  task automatic test_outside();
    new_frame();
    step(640, 10, 1, 1, 1, 1);
    step(10, 480, 1, 1, 1, 1);
    checks++;
    if ({collision_ghost, collision_player, hit_ghost} !== 3'b000) begin
      failures++;
      $display("FAIL outside_masked got=%b exp=000", {collision_ghost, collision_player, hit_ghost});
    end
    step(639, 479, 0, 1, 0, 1);
    checks++;
    if (collision_player !== 1'b1) begin
      failures++;
      $display("FAIL edge_pixel_player got=%b exp=1", collision_player);
    end
  endtask
  task automatic test_sof_priority();
    new_frame();
    step(5, 5, 1, 0, 0, 1);
    step(639, 479, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    checks++;
    if ({collision_ghost, frame_start} !== 2'b11) begin
      failures++;
      $display("FAIL sof_priority got=%b exp=11", {collision_ghost, frame_start});
    end
    step(1, 0, 1, 0, 0, 1);
    checks++;
    if (collision_ghost !== 1'b0) begin
      failures++;
      $display("FAIL sof_priority_fired got=%b exp=0", collision_ghost);
    end
  endtask
  task automatic test_random();
    int x, y;
    for (int i = 0; i < 2000; i++) begin
      x = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 700));
      y = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 520));
      step(x, y, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if ({collision_ghost, collision_player, hit_ghost, frame_start, hit_count} !==
          {m_pulse[0], m_pulse[1], m_pulse[2], m_fs, 8'(m_cnt)}) begin
        failures++;
        $display("FAIL random cycle=%0d got=%b%b%b%b/%0d exp=%b%b%b%b/%0d", i,
                 collision_ghost, collision_player, hit_ghost, frame_start, hit_count,
                 m_pulse[0], m_pulse[1], m_pulse[2], m_fs, m_cnt);
      end
    end
  endtask
  task automatic test_saturation();
    for (int f = 0; f < 300; f++) begin
      new_frame();
      step(50 + int'($urandom_range(0, 9)), 50, 1, 0, 1, 0);
      step(60, 60, 0, 0, 0, 0);
      checks++;
      if (hit_count !== 8'(m_cnt)) begin
        failures++;
        $display("FAIL sat_track frame=%0d got=%0d exp=%0d", f, hit_count, m_cnt);
      end
    end
    checks++;
    if (hit_count !== 8'd255) begin
      failures++;
      $display("FAIL sat_hold got=%0d exp=255", hit_count);
    end
  endtask
  task automatic test_reset_mid_pulse();
    new_frame();
    step(200, 200, 1, 1, 1, 0);
    checks++;
    if ({collision_ghost, collision_player, hit_ghost} !== 3'b111) begin
      failures++;
      $display("FAIL pre_reset_pulses got=%b exp=111", {collision_ghost, collision_player, hit_ghost});
    end
    resetN = 0;
    #1;
    checks++;
    if ({collision_ghost, collision_player, hit_ghost, frame_start, hit_count} !== 12'h0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=000", {collision_ghost, collision_player, hit_ghost, frame_start, hit_count});
    end
    model_reset();
    @(posedge clk);
    #1;
    resetN = 1;
    step(200, 200, 1, 0, 0, 1);
    checks++;
    if ({collision_ghost, hit_count} !== 9'b1_0000_0000) begin
      failures++;
      $display("FAIL post_reset_armed got=%b/%0d exp=1/0", collision_ghost, hit_count);
    end
  endtask
  initial begin
    test_reset();
    test_ghost_hold();
    test_hit();
    test_outside();
    test_sof_priority();
    test_random();
    test_saturation();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/collision_detector.md
# collision_detector

Per-pixel collision detector downstream of the object draw units (ghost, player, missile, borders). It samples each unit's draw flag at the current pixel, registers one-cycle collision pulses, and feeds `collision` back into the ghost and player movement units. Each collision class fires at most once per video frame. It also keeps a saturating ghost-hit counter for the score logic.

## Interface
Parameters:
- `H_ACTIVE`, default 640: visible pixels per line. Draw flags at `pxl_x >= H_ACTIVE` are ignored.
- `V_ACTIVE`, default 480: visible lines. Draw flags at `pxl_y >= V_ACTIVE` are ignored.
- `CNT_W`, default 8: width of `hit_count`.

Ports:
- `clk`  in  1: system clock.
- `resetN`  in  1: asynchronous, active-low reset.
- `pxl_x`  in  32: current pixel column from the VGA controller.
- `pxl_y`  in  32: current pixel row.
- `draw_ghost`  in  1: ghost unit `Draw`.
- `draw_player`  in  1: player unit draw flag.
- `draw_missile`  in  1: missile unit draw flag.
- `draw_border`  in  1: border/background wall draw flag.
- `collision_ghost`  out  1: one-cycle pulse to the ghost movement unit.
- `collision_player`  out  1: one-cycle pulse to the player movement unit.
- `hit_ghost`  out  1: one-cycle pulse when the missile overlaps the ghost (score event).
- `frame_start`  out  1: one-cycle pulse at the start of each frame.
- `hit_count`  out  CNT_W: number of ghost hits since reset, saturating.

## Operation
Active pixel: `pxl_x < H_ACTIVE && pxl_y < V_ACTIVE`. All overlap terms are masked to 0 outside the active area.

Overlap terms are combinational from the inputs:
- `ov_gb = draw_ghost & draw_border`
- `ov_gm = draw_ghost & draw_missile`
- `ov_pg = draw_player & draw_ghost`
- `ov_pb = draw_player & draw_border`

Event classes, each with its own latch:
- GHOST: `ov_gb | ov_gm`, drives `collision_ghost`.
- PLAYER: `ov_pg | ov_pb`, drives `collision_player`.
- HIT: `ov_gm`, drives `hit_ghost` and increments `hit_count`.

Per-class state machine, two states:
- ARMED -> FIRED when the class term is 1. In that cycle the output pulse register is set for exactly one cycle.
- FIRED -> ARMED on internal `sof`. No pulses are issued while FIRED.

Frame start detection:
- `sof` = coordinates are (0,0) this cycle AND were not (0,0) last cycle.
- This is edge-based because the pixel clock enable may hold the coordinates for several `clk` cycles.
- `frame_start` is `sof` registered.

Hit counter:
- `hit_count` increments by 1 on each `hit_ghost` pulse.
- At `2^CNT_W - 1` it holds; it does not wrap.

Simultaneous events:
- `sof` and a class term in the same cycle: the frame clear takes priority. The latch re-arms, the term is evaluated in the new frame, the pulse fires, and the latch ends FIRED.
- GHOST and HIT in the same cycle (missile on ghost): both `collision_ghost` and `hit_ghost` pulse.

Reset:
- Assertion at any time, including mid-frame or mid-pulse, immediately clears everything.
- After reset: all outputs 0, `hit_count` = 0, all latches ARMED, previous-(0,0) register = 1.
- Because the previous-(0,0) register resets to 1, no spurious `frame_start` fires if the coordinates are already (0,0) on reset release.

## Timing
- Latency: 1 clock. A class term true at edge t gives its pulse high from edge t to edge t+1.
- Pulse width: exactly 1 `clk` cycle, regardless of how long the overlap persists.
- `frame_start`: 1 cycle after the first cycle at (0,0).
- `hit_count` updates in the same cycle as `hit_ghost` is high, so the new value is visible at edge t+1.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Package `collision_pkg`:
  - `typedef enum logic {ARMED, FIRED} latch_state_t`
  - default localparams `H_ACTIVE_DEF = 640`, `V_ACTIVE_DEF = 480`
- Sub-module `collision_latch`: ports `clk`, `resetN`, `sof`, `event_in`, `pulse_out`. It is instantiated three times (GHOST, PLAYER, HIT).
- Top level contains the active-area masking, the overlap terms, the `sof` edge detector and the saturating counter.

## Test plan
- Reset release with coordinates already at (0,0) -> `frame_start` stays 0 and all outputs are 0. Next transition from (639,479) to (0,0) -> `frame_start` pulses once.
- `draw_ghost` and `draw_border` held high for 20 cycles at (100,50)..(119,50) -> exactly one `collision_ghost` pulse, 1 cycle after the first overlap. No further pulse until `sof`. After `sof`, a repeated overlap -> one new pulse.
- Missile overlaps ghost at (200,200) -> `collision_ghost` and `hit_ghost` pulse in the same cycle, and `hit_count` goes 0 -> 1.
- All draw flags high at `pxl_x = 640` (outside the active area) -> no pulses.
- Overlap in the same cycle as `sof` after a FIRED frame -> pulse fires, and the latch is FIRED for the new frame.
- Force 300 frames each containing a ghost hit -> `hit_count` reaches 255 and holds. `resetN` low mid-pulse -> all outputs 0 immediately and `hit_count` = 0.
